// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC receive path.
// Descriptor fields, reader FSM encoding and default length limits.
package mac_pkg;

    localparam int PTR_ERR_BIT = 15;
    localparam int PTR_LEN_MSB = 11;
    localparam int PTR_LEN_LSB = 0;
    localparam int LEN_W       = PTR_LEN_MSB - PTR_LEN_LSB + 1;

    localparam int DEF_MIN_LEN = 60;
    localparam int DEF_MAX_LEN = 1518;

    typedef enum logic [1:0] {
        IDLE,
        PTR_WAIT,
        FWD,
        DROP
    } rx_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
        logic       last;
    } rx_beat_t;

endpackage

// File: rtl/mac_rx_skid2.sv
// Two-entry valid/ready skid buffer with fall-through when empty.
// The writer guarantees it never pushes into a full buffer.
module mac_rx_skid2
    import mac_pkg::*;
#(
    parameter int W = $bits(rx_beat_t)
) (
    input  logic         clk,
    input  logic         rst_sys,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occ
);

    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic [1:0]   count;
    logic         pop;

    assign pop = out_valid && out_ready;
    assign occ = count;

    // Empty buffer passes the incoming beat straight to the head.
    always_comb begin
        out_valid = (count != 2'd0) || in_valid;
        out_data  = '0;
        if (count != 2'd0) begin
            out_data = head;
        end else if (in_valid) begin
            out_data = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_sys) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            unique case (count)
                2'd0: begin
                    if (in_valid && !pop) begin
                        head  <= in_data;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (pop && in_valid) begin
                        head <= in_data;
                    end else if (pop) begin
                        count <= 2'd0;
                    end else if (in_valid) begin
                        tail  <= in_data;
                        count <= 2'd2;
                    end
                end
                default: begin
                    if (pop) begin
                        head <= tail;
                        if (in_valid) begin
                            tail <= in_data;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/mac_rx_reader.sv
// Drains MAC rx descriptor/data FIFOs into a byte stream, dropping bad frames.
// Define MAC_RX_READER_STATS_EN to add forward/drop frame counters.
module mac_rx_reader
    import mac_pkg::*;
#(
    parameter int MIN_LEN = DEF_MIN_LEN,
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic        clk,
    input  logic        rst_sys,
    output logic        ptr_fifo_rd,
    input  logic [15:0] ptr_fifo_dout,
    input  logic        ptr_fifo_empty,
    output logic        data_fifo_rd,
    input  logic [7:0]  data_fifo_dout,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        o_ready,
    output logic        o_first,
    output logic        o_last,
    output logic [11:0] o_len,
    output logic        busy
`ifdef MAC_RX_READER_STATS_EN
    ,
    output logic [31:0] stat_fwd_cnt,
    output logic [31:0] stat_drop_cnt
`endif
);

    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);

    rx_state_t        state;
    rx_state_t        state_nx;
    logic [LEN_W-1:0] rem;
    logic [LEN_W-1:0] desc_len;
    logic             desc_err;
    logic             desc_zero;
    logic             desc_bad;
    logic [2:0]       rsvd_unused;
    logic             first_pend;
    logic             inf_vld;
    logic             inf_first;
    logic             inf_last;
    logic [1:0]       occ;
    logic [1:0]       pend;
    logic             fwd_rd;
    logic             rd;
    logic             accept_last;
    rx_beat_t         skid_in;
    rx_beat_t         skid_out;

    assign desc_len    = ptr_fifo_dout[PTR_LEN_MSB:PTR_LEN_LSB];
    assign desc_err    = ptr_fifo_dout[PTR_ERR_BIT];
    assign rsvd_unused = ptr_fifo_dout[14:12];
    assign desc_zero   = (desc_len == '0);
    assign desc_bad    = desc_err || (desc_len < MIN_L)
                      || (desc_len > MAX_L);

    // Stored beats plus the read in flight never exceed two.
    assign pend   = occ + {1'b0, inf_vld};
    assign fwd_rd = (state == FWD) && (rem != '0) && (pend < 2'd2);
    assign rd     = fwd_rd || (state == DROP);

    assign accept_last = o_valid && o_ready && o_last;

    always_ff @(posedge clk) begin
        if (rst_sys) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (!ptr_fifo_empty) state_nx = PTR_WAIT;
            end
            PTR_WAIT: begin
                if (desc_zero)     state_nx = IDLE;
                else if (desc_bad) state_nx = DROP;
                else               state_nx = FWD;
            end
            DROP: begin
                if (rem == ONE) state_nx = IDLE;
            end
            default: begin
                if (accept_last) state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        ptr_fifo_rd  = 1'b0;
        data_fifo_rd = 1'b0;
        if (!rst_sys) begin
            ptr_fifo_rd  = (state == IDLE) && !ptr_fifo_empty;
            data_fifo_rd = rd;
        end
        busy = (state != IDLE);
    end

    // Tags travel with the read and meet the byte when dout arrives.
    always_ff @(posedge clk) begin
        if (rst_sys) begin
            rem        <= '0;
            o_len      <= '0;
            first_pend <= 1'b0;
            inf_vld    <= 1'b0;
            inf_first  <= 1'b0;
            inf_last   <= 1'b0;
        end else begin
            inf_vld   <= fwd_rd;
            inf_first <= first_pend;
            inf_last  <= (rem == ONE);
            if (state == PTR_WAIT) begin
                rem        <= desc_len;
                first_pend <= !desc_zero && !desc_bad;
                if (!desc_zero && !desc_bad) o_len <= desc_len;
            end else if (rd) begin
                rem        <= rem - ONE;
                first_pend <= 1'b0;
            end
        end
    end

    assign skid_in = '{data: data_fifo_dout,
                       first: inf_first,
                       last: inf_last};

    mac_rx_skid2 u_skid (
        .clk       (clk),
        .rst_sys   (rst_sys),
        .in_valid  (inf_vld),
        .in_data   (skid_in),
        .out_valid (o_valid),
        .out_ready (o_ready),
        .out_data  (skid_out),
        .occ       (occ)
    );

    assign o_data  = skid_out.data;
    assign o_first = skid_out.first;
    assign o_last  = skid_out.last;

`ifdef MAC_RX_READER_STATS_EN
    logic drop_ev;

    assign drop_ev = (state == PTR_WAIT) && (desc_zero || desc_bad);

    always_ff @(posedge clk) begin
        if (rst_sys) begin
            stat_fwd_cnt  <= '0;
            stat_drop_cnt <= '0;
        end else begin
            if (accept_last && !(&stat_fwd_cnt))
                stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
            if (drop_ev && !(&stat_drop_cnt))
                stat_drop_cnt <= stat_drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_rx_reader.sv
// Bench for mac_rx_reader: FIFO models, frame-level reference, directed steps.
// Build with MAC_RX_READER_STATS_EN to also exercise the counters.
module tb_mac_rx_reader;

    logic        clk = 1'b0;
    logic        rst_sys = 1'b1;
    logic        ptr_fifo_rd;
    logic [15:0] ptr_fifo_dout = '0;
    logic        ptr_fifo_empty = 1'b1;
    logic        data_fifo_rd;
    logic [7:0]  data_fifo_dout = '0;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic        o_first;
    logic        o_last;
    logic [11:0] o_len;
    logic        busy;
`ifdef MAC_RX_READER_STATS_EN
    logic [31:0] stat_fwd_cnt;
    logic [31:0] stat_drop_cnt;
`endif

    mac_rx_reader dut (
        .clk            (clk),
        .rst_sys        (rst_sys),
        .ptr_fifo_rd    (ptr_fifo_rd),
        .ptr_fifo_dout  (ptr_fifo_dout),
        .ptr_fifo_empty (ptr_fifo_empty),
        .data_fifo_rd   (data_fifo_rd),
        .data_fifo_dout (data_fifo_dout),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_ready        (o_ready),
        .o_first        (o_first),
        .o_last         (o_last),
        .o_len          (o_len),
        .busy           (busy)
`ifdef MAC_RX_READER_STATS_EN
        ,
        .stat_fwd_cnt   (stat_fwd_cnt),
        .stat_drop_cnt  (stat_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  d;
        logic        f;
        logic        l;
        logic [11:0] n;
    } beat_t;

    logic [15:0] pq[$];
    logic [7:0]  dq[$];
    beat_t       expq[$];
    beat_t       gotq[$];
    int          gotc[$];
    int          ptrc[$];
    int          rdc[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int uflow = 0;
    int rd_cnt = 0;
    int acc_cnt = 0;
    int rd_base = 0;
    int exp_rd = 0;
    int diff_base = 1 << 30;
    int max_out = 0;
    int rdy_mode = 1;

    // Non-FWFT FIFO models: dout updates the edge after rd.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_sys) begin
            pq.delete();
            dq.delete();
            ptr_fifo_dout  <= '0;
            data_fifo_dout <= '0;
            ptr_fifo_empty <= 1'b1;
        end else begin
            if (ptr_fifo_rd) begin
                if (pq.size() > 0) ptr_fifo_dout <= pq.pop_front();
                else uflow <= uflow + 1;
            end
            if (data_fifo_rd) begin
                if (dq.size() > 0) data_fifo_dout <= dq.pop_front();
                else uflow <= uflow + 1;
            end
            ptr_fifo_empty <= (pq.size() == 0);
        end
    end

    always @(negedge clk) begin : mon
        int diff;
        if (!rst_sys) begin
            if (ptr_fifo_rd) ptrc.push_back(cyc);
            if (data_fifo_rd) begin
                rdc.push_back(cyc);
                rd_cnt = rd_cnt + 1;
            end
            if (o_valid && o_ready) begin
                gotq.push_back('{d: o_data, f: o_first,
                                 l: o_last, n: o_len});
                gotc.push_back(cyc);
                acc_cnt = acc_cnt + 1;
            end
            diff = rd_cnt - acc_cnt - diff_base;
            if (diff > max_out) max_out = diff;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       o_ready = 1'b0;
                1:       o_ready = 1'b1;
                default: o_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check(string tag, logic [63:0] obs,
                         logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // Reference: a frame is forwarded whole iff error-free and in range.
    task automatic send(int len, bit err);
        logic [15:0] d;
        logic [7:0]  b;
        bit          fwd;
        d = {err, 3'($urandom), 12'(len)};
        fwd = !err && len >= 60 && len <= 1518;
        pq.push_back(d);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            dq.push_back(b);
            if (fwd)
                expq.push_back('{d: b, f: (i == 0),
                                 l: (i == len - 1), n: 12'(len)});
        end
        exp_rd += len;
    endtask

    task automatic drain(string tag, int budget);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (pq.size() == 0) && (dq.size() == 0) && !busy
                && (gotq.size() >= expq.size());
        end
        check({tag, "_drain"}, 64'(done), 64'd1);
    endtask

    task automatic compare(string tag);
        check({tag, "_count"}, 64'(gotq.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < gotq.size(); i++)
            check($sformatf("%s[%0d]", tag, i),
                  64'(gotq[i]), 64'(expq[i]));
        check({tag, "_reads"}, 64'(rd_cnt - rd_base), 64'(exp_rd));
        gotq.delete();
        expq.delete();
        rd_base = rd_cnt;
        exp_rd = 0;
    endtask

    task automatic check_idle(string tag);
        check(tag, 64'({o_valid, o_first, o_last, o_data, o_len,
                        busy, ptr_fifo_rd, data_fifo_rd}), 64'd0);
`ifdef MAC_RX_READER_STATS_EN
        check({tag, "_stats"}, {stat_fwd_cnt, stat_drop_cnt}, 64'd0);
`endif
    endtask

    initial begin : main
        int gap;
        int lat_rd;
        int lat_v;
        int got30;
`ifdef MAC_RX_READER_STATS_EN
        int drop0;
`endif
        rdy_mode = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset_state");
        rst_sys = 1'b0;

        ptrc.delete();
        rdc.delete();
        gotc.delete();
        send(64, 1'b0);
        drain("good64", 400);
        lat_rd = (rdc.size() > 0 && ptrc.size() > 0)
               ? rdc[0] - ptrc[0] : -1;
        lat_v = (gotc.size() > 0 && ptrc.size() > 0)
              ? gotc[0] - ptrc[0] : -1;
        check("lat_first_rd", 64'(lat_rd), 64'd2);
        check("lat_first_valid", 64'(lat_v), 64'd3);
        compare("good64");

        send(64, 1'b1);
        send(64, 1'b0);
        drain("err_then_good", 600);
        compare("err_then_good");

`ifdef MAC_RX_READER_STATS_EN
        drop0 = int'(stat_drop_cnt);
`endif
        send(59, 1'b0);
        send(1519, 1'b0);
        send(0, 1'b0);
        drain("short_long_zero", 4000);
        compare("short_long_zero");
`ifdef MAC_RX_READER_STATS_EN
        check("stat_drop_delta", 64'(int'(stat_drop_cnt) - drop0),
              64'd3);
`endif

        send(60, 1'b0);
        send(1518, 1'b0);
        drain("bounds", 4000);
        compare("bounds");

        rdy_mode = 2;
        diff_base = rd_cnt - acc_cnt;
        send(100, 1'b0);
        drain("ready_rand", 2000);
        compare("ready_rand");
        check("outstanding_le2", 64'(max_out <= 2), 64'd1);

        for (int k = 0; k < 6; k++)
            send($urandom_range(1, 300), ($urandom_range(0, 3) == 0));
        drain("random_mix", 8000);
        compare("random_mix");

        rdy_mode = 1;
        gotc.delete();
        send(60, 1'b0);
        send(60, 1'b0);
        drain("b2b", 600);
        gap = (gotc.size() >= 61) ? gotc[60] - gotc[59] - 1 : -1;
        check("b2b_gap", 64'(gap), 64'd3);
        compare("b2b");

        send(200, 1'b0);
        got30 = 0;
        for (int n = 0; n < 400 && got30 == 0; n++) begin
            @(negedge clk);
            if (gotq.size() >= 30) got30 = 1;
        end
        check("mid_reset_reached", 64'(got30), 64'd1);
        rst_sys = 1'b1;
        for (int i = 0; i < 30 && i < gotq.size(); i++)
            check($sformatf("pre_reset[%0d]", i),
                  64'(gotq[i]), 64'(expq[i]));
        @(posedge clk);
        @(negedge clk);
        check_idle("mid_reset_state");
        rst_sys = 1'b0;
        gotq.delete();
        expq.delete();
        rd_base = rd_cnt;
        exp_rd = 0;

        send(64, 1'b0);
        drain("after_reset", 400);
        compare("after_reset");
`ifdef MAC_RX_READER_STATS_EN
        check("stat_after_reset",
              {stat_fwd_cnt, stat_drop_cnt}, {32'd1, 32'd0});
`endif
        check("fifo_underflow", 64'(uflow), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
